soc_fb_fill_ctrl: RTL and testbench
===================================

# soc_fb_fill_ctrl

Framebuffer access controller: owns the single write/read port of the VGA framebuffer memory and shares it between the CPU path and a built-in rectangle-fill engine. Sits between the SoC memory bus decode and the framebuffer's bus-side port, in the main clock domain. Fills an axis-aligned rectangle with one 8-bit colour at one pixel per free cycle, with bounded CPU priority.

## Interface
- `ADDR_W`, 19: framebuffer byte (pixel) address width.
- `H_RES`, 640: pixels per line.
- `V_RES`, 480: visible lines.
- `FB_BASE`, 0: pixel address of (0,0).
- `FB_LATENCY`, 1: framebuffer read latency in cycles (1..4).
- `STARVE_LIMIT`, 8: consecutive engine-stall cycles before the engine is forced a slot.

Ports:
- `main_clk` in 1: clock. Single clock domain; reset is synchronous and active-high.
- `res` in 1: reset.
- `cfg_x0` in 10, `cfg_y0` in 9, `cfg_w` in 10, `cfg_h` in 9: rectangle origin and size, sampled on accepted `start`.
- `cfg_color` in 8: fill value, sampled on accepted `start`.
- `start` in 1: start a fill; accepted only in IDLE.
- `abort` in 1: stop the fill.
- `busy` out 1: fill in progress.
- `done` out 1: one-cycle completion pulse.
- `cpu_req` in 1, `cpu_we` in 1, `cpu_addr` in ADDR_W, `cpu_wdata` in 8: CPU access.
- `cpu_gnt` out 1: combinational; CPU access performed this cycle.
- `cpu_rvalid` out 1, `cpu_rdata` out 8: read return.
- `fb_req` out 1, `fb_we` out 1, `fb_addr` out ADDR_W, `fb_wdata` out 8: framebuffer port.
- `fb_rdata` in 8: framebuffer read data, valid FB_LATENCY cycles after a read `fb_req`.

## Operation
- FSM states: IDLE, FILL, DONE.
  - IDLE -> FILL on `start`.
  - FILL -> DONE after the last pixel write, or on `abort`.
  - DONE -> IDLE unconditionally. `done` is high only in DONE.
- `start` outside IDLE is ignored.
- `busy` is high in FILL only.
- Clipping is applied at start with 11-bit arithmetic:
  - x_end = min(x0+w, H_RES), y_end = min(y0+h, V_RES).
  - If w==0, h==0, x0>=H_RES or y0>=V_RES, go IDLE -> DONE directly with no writes.
- Scan order is row-major: x from x0 to x_end-1, then y+1.
- Addressing is incremental and uses no multiplier:
  - row_base = FB_BASE + y0*H_RES, computed at start by a shift/add constant multiply.
  - row_base += H_RES per row.
  - fb_addr = row_base + x.
- Arbitration, once per cycle:
  - CPU wins when `cpu_req` is high, unless the stall counter equals STARVE_LIMIT.
  - The stall counter increments in each FILL cycle the engine loses. It clears when the engine writes, and in IDLE.
  - When the engine is forced a slot, `cpu_gnt` is 0 and the CPU must hold its request.
  - Outside FILL, `cpu_gnt` = `cpu_req`.
- Reads:
  - A granted CPU read enters a FB_LATENCY-deep valid shift register.
  - `cpu_rvalid` is asserted with `cpu_rdata` = `fb_rdata` exactly FB_LATENCY cycles after the grant.
  - Back-to-back reads pipeline fully.
- `abort` in FILL: no write in that cycle or later, next state is DONE. In any other state `abort` is ignored.
- `abort` and completion in the same cycle: abort wins and that final write is suppressed.

## Timing
- Reset values: `busy`, `done`, `cpu_gnt`, `cpu_rvalid`, `fb_req`, `fb_we` = 0; `fb_addr`, `fb_wdata`, `cpu_rdata` = 0. Reset also sets state IDLE, stall counter 0 and clears the read pipe.
- `res` mid-fill drops everything in the same edge; no further writes.
- `start` at cycle t, uncontended:
  - writes occur in cycles t+1 .. t+N, where N = clipped w*h;
  - `done` is high in cycle t+N+1.
- Degenerate `start` at cycle t: `done` is high at t+1.
- The `fb_*` outputs are a combinational mux of registered engine state and the CPU inputs. There is no added latency on the CPU write path.

## Structure
- Package `soc_fb_pkg` holds the H_RES/V_RES defaults, `pixel_t` (logic [7:0]) and the `fill_state_t` enum.
- Sub-module `soc_fb_fill_walker` holds the clipped x/y counters, the row_base adder and the last-pixel flag. It has advance/load inputs and addr/last outputs.
- The top level holds the FSM, the arbiter, the stall counter and the read pipe.

## Test plan
- Plain fill:
  - Stimulus: x0=10, y0=20, w=3, h=2, colour 0x5A, no CPU traffic.
  - Required: writes to 12810, 12811, 12812, 13450, 13451, 13452 in cycles t+1..t+6, `done` at t+7, `busy` high t+1..t+6.
- Clipped fill:
  - Stimulus: x0=638, y0=479, w=5, h=4.
  - Required: exactly two writes, to 307198 and 307199, then `done`.
- Degenerate fills:
  - Stimulus: w=0; separately x0=700.
  - Required: zero `fb_req`, `done` the cycle after `start`.
- Contention:
  - Stimulus: `cpu_req` held high for 20 cycles during a 100-pixel fill.
  - Required: the engine writes only in contended cycles 9 and 18, with `cpu_gnt` low in those cycles; every other cycle is a CPU grant.
- CPU reads:
  - Stimulus: FB_LATENCY=2, reads of 100 then 101 back-to-back.
  - Required: `cpu_rvalid` high 2 cycles after each grant, carrying the matching data.
- Abort and reset:
  - Stimulus: `abort` after 5 writes of a 3x3 fill.
  - Required: no 6th write, `done` the next cycle, IDLE after. A new `start` then works.
  - Stimulus: `res` mid-fill.
  - Required: all outputs 0 the next cycle.

Source files
------------

// File: rtl/soc_fb_pkg.sv
// Shared types and defaults for the framebuffer fill controller.
// Also holds a shift/add constant multiply so no multiplier is inferred.
package soc_fb_pkg;

  localparam int DEF_H_RES = 640;
  localparam int DEF_V_RES = 480;

  typedef logic [7:0] pixel_t;

  typedef enum logic [1:0] {
    FS_IDLE = 2'd0,
    FS_FILL = 2'd1,
    FS_DONE = 2'd2
  } fill_state_t;

  // k is always an elaboration-time constant, so this unrolls into a fixed adder tree
  function automatic logic [31:0] mul_const(input logic [31:0] v, input int k);
    logic [31:0] acc;
    acc = '0;
    for (int i = 0; i < 32; i++) begin
      if (k[i]) acc = acc + (v << i);
    end
    return acc;
  endfunction

endpackage

// File: rtl/soc_fb_fill_walker.sv
// Clipped rectangle walker: row-major x/y counters with an incremental row base,
// producing the current pixel address and a last-pixel flag.
module soc_fb_fill_walker
  import soc_fb_pkg::*;
#(
  parameter int ADDR_W  = 19,
  parameter int H_RES   = DEF_H_RES,
  parameter int V_RES   = DEF_V_RES,
  parameter int FB_BASE = 0
) (
  input  logic              main_clk,
  input  logic              res,
  input  logic              load,
  input  logic              advance,
  input  logic [9:0]        cfg_x0,
  input  logic [8:0]        cfg_y0,
  input  logic [9:0]        cfg_w,
  input  logic [8:0]        cfg_h,
  output logic              empty,
  output logic [ADDR_W-1:0] addr,
  output logic              last
);

  localparam logic [10:0]       H_LIM    = 11'(H_RES);
  localparam logic [10:0]       V_LIM    = 11'(V_RES);
  localparam logic [ADDR_W-1:0] ROW_STEP = ADDR_W'(H_RES);

  logic [10:0]       x_sum, y_sum, x_end, y_end;
  logic [10:0]       x, x0_q, x_last, y, y_last;
  logic [ADDR_W-1:0] row_base, row_base_init;

  // Clip against the screen edge in 11 bits so x0+w cannot wrap
  always_comb begin
    x_sum = {1'b0, cfg_x0} + {1'b0, cfg_w};
    y_sum = {2'b0, cfg_y0} + {2'b0, cfg_h};
    x_end = (x_sum > H_LIM) ? H_LIM : x_sum;
    y_end = (y_sum > V_LIM) ? V_LIM : y_sum;
    empty = (cfg_w == '0) || (cfg_h == '0) ||
            ({1'b0, cfg_x0} >= H_LIM) || ({2'b0, cfg_y0} >= V_LIM);
    row_base_init = ADDR_W'(mul_const({23'b0, cfg_y0}, H_RES) + 32'(FB_BASE));
  end

  always_ff @(posedge main_clk) begin
    if (res) begin
      x        <= '0;
      x0_q     <= '0;
      x_last   <= '0;
      y        <= '0;
      y_last   <= '0;
      row_base <= '0;
    end else if (load) begin
      x        <= {1'b0, cfg_x0};
      x0_q     <= {1'b0, cfg_x0};
      x_last   <= x_end - 11'd1;
      y        <= {2'b0, cfg_y0};
      y_last   <= y_end - 11'd1;
      row_base <= row_base_init;
    end else if (advance) begin
      if (x == x_last) begin
        x        <= x0_q;
        y        <= y + 11'd1;
        row_base <= row_base + ROW_STEP;
      end else begin
        x <= x + 11'd1;
      end
    end
  end

  assign addr = row_base + ADDR_W'(x);
  assign last = (x == x_last) && (y == y_last);

endmodule

// File: rtl/soc_fb_fill_ctrl.sv
// Framebuffer port owner: arbitrates CPU accesses against the rectangle-fill
// engine with a starvation bound, and returns CPU read data through a valid pipe.
module soc_fb_fill_ctrl
  import soc_fb_pkg::*;
#(
  parameter int ADDR_W       = 19,
  parameter int H_RES        = DEF_H_RES,
  parameter int V_RES        = DEF_V_RES,
  parameter int FB_BASE      = 0,
  parameter int FB_LATENCY   = 1,
  parameter int STARVE_LIMIT = 8
) (
  input  logic              main_clk,
  input  logic              res,
  input  logic [9:0]        cfg_x0,
  input  logic [8:0]        cfg_y0,
  input  logic [9:0]        cfg_w,
  input  logic [8:0]        cfg_h,
  input  logic [7:0]        cfg_color,
  input  logic              start,
  input  logic              abort,
  output logic              busy,
  output logic              done,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [7:0]        cpu_wdata,
  output logic              cpu_gnt,
  output logic              cpu_rvalid,
  output logic [7:0]        cpu_rdata,
  output logic              fb_req,
  output logic              fb_we,
  output logic [ADDR_W-1:0] fb_addr,
  output logic [7:0]        fb_wdata,
  input  logic [7:0]        fb_rdata
);

  localparam logic [1:0] ST_IDLE = FS_IDLE;
  localparam logic [1:0] ST_FILL = FS_FILL;
  localparam logic [1:0] ST_DONE = FS_DONE;

  localparam int             SW        = $clog2(STARVE_LIMIT + 1);
  localparam logic [SW-1:0]  STALL_MAX = SW'(STARVE_LIMIT);

  logic [1:0]            state, state_nxt;
  logic [SW-1:0]         stall;
  pixel_t                color_q;
  logic [FB_LATENCY-1:0] rd_pipe;
  logic                  in_fill, eng_forced, eng_wr, walk_load;
  logic                  walk_empty, walk_last;
  logic [ADDR_W-1:0]     walk_addr;

  assign in_fill    = (state == ST_FILL) && !res;
  assign eng_forced = (stall == STALL_MAX);
  assign eng_wr     = in_fill && !abort && (!cpu_req || eng_forced);
  assign cpu_gnt    = cpu_req && !res && !eng_wr;
  assign walk_load  = (state == ST_IDLE) && start;

  soc_fb_fill_walker #(
    .ADDR_W  (ADDR_W),
    .H_RES   (H_RES),
    .V_RES   (V_RES),
    .FB_BASE (FB_BASE)
  ) u_walker (
    .main_clk (main_clk),
    .res      (res),
    .load     (walk_load),
    .advance  (eng_wr),
    .cfg_x0   (cfg_x0),
    .cfg_y0   (cfg_y0),
    .cfg_w    (cfg_w),
    .cfg_h    (cfg_h),
    .empty    (walk_empty),
    .addr     (walk_addr),
    .last     (walk_last)
  );

  // Port mux: idle port drives zeros so nothing stale leaks onto the bus
  always_comb begin
    fb_req   = eng_wr || cpu_gnt;
    fb_we    = eng_wr || (cpu_gnt && cpu_we);
    fb_addr  = '0;
    fb_wdata = '0;
    if (eng_wr) begin
      fb_addr  = walk_addr;
      fb_wdata = color_q;
    end else if (cpu_gnt) begin
      fb_addr  = cpu_addr;
      fb_wdata = cpu_wdata;
    end
  end

  // Abort takes priority over completing the final pixel (eng_wr is already low)
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (start) state_nxt = walk_empty ? ST_DONE : ST_FILL;
      ST_FILL: if (abort || (eng_wr && walk_last)) state_nxt = ST_DONE;
      ST_DONE: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge main_clk) begin
    if (res) begin
      state   <= ST_IDLE;
      stall   <= '0;
      color_q <= '0;
      rd_pipe <= '0;
    end else begin
      state <= state_nxt;
      if (walk_load) color_q <= cfg_color;
      if (state != ST_FILL || eng_wr) stall <= '0;
      else if (cpu_req) stall <= stall + SW'(1);
      rd_pipe[0] <= cpu_gnt && !cpu_we;
      for (int i = 1; i < FB_LATENCY; i++) rd_pipe[i] <= rd_pipe[i-1];
    end
  end

  assign busy       = (state == ST_FILL);
  assign done       = (state == ST_DONE);
  assign cpu_rvalid = rd_pipe[FB_LATENCY-1];
  assign cpu_rdata  = cpu_rvalid ? fb_rdata : 8'h00;

endmodule

// File: tb/tb_soc_fb_fill_ctrl.sv
// Directed bench for soc_fb_fill_ctrl: fills, clipping, contention, reads, abort, reset.
module tb_soc_fb_fill_ctrl;

  logic        main_clk = 1'b0;
  logic        res;
  logic [9:0]  cfg_x0, cfg_w;
  logic [8:0]  cfg_y0, cfg_h;
  logic [7:0]  cfg_color;
  logic        start, abort;
  logic        busy, done;
  logic        cpu_req, cpu_we;
  logic [18:0] cpu_addr;
  logic [7:0]  cpu_wdata;
  logic        cpu_gnt, cpu_rvalid;
  logic [7:0]  cpu_rdata;
  logic        fb_req, fb_we;
  logic [18:0] fb_addr;
  logic [7:0]  fb_wdata, fb_rdata;
  logic [7:0]  rd_d1 = 8'h00, rd_d2 = 8'h00;

  int total = 0;
  int bad   = 0;

  always #5 main_clk = ~main_clk;

  soc_fb_fill_ctrl #(
    .ADDR_W       (19),
    .H_RES        (640),
    .V_RES        (480),
    .FB_BASE      (0),
    .FB_LATENCY   (2),
    .STARVE_LIMIT (8)
  ) dut (
    .main_clk   (main_clk),
    .res        (res),
    .cfg_x0     (cfg_x0),
    .cfg_y0     (cfg_y0),
    .cfg_w      (cfg_w),
    .cfg_h      (cfg_h),
    .cfg_color  (cfg_color),
    .start      (start),
    .abort      (abort),
    .busy       (busy),
    .done       (done),
    .cpu_req    (cpu_req),
    .cpu_we     (cpu_we),
    .cpu_addr   (cpu_addr),
    .cpu_wdata  (cpu_wdata),
    .cpu_gnt    (cpu_gnt),
    .cpu_rvalid (cpu_rvalid),
    .cpu_rdata  (cpu_rdata),
    .fb_req     (fb_req),
    .fb_we      (fb_we),
    .fb_addr    (fb_addr),
    .fb_wdata   (fb_wdata),
    .fb_rdata   (fb_rdata)
  );

  // Framebuffer model: two-cycle read latency, data = low address byte + 0x30
  always @(posedge main_clk) begin
    rd_d1 <= (fb_req && !fb_we) ? fb_addr[7:0] + 8'h30 : 8'h00;
    rd_d2 <= rd_d1;
  end
  assign fb_rdata = rd_d2;

  task automatic test_reset;
    res = 1'b1; start = 1'b0; abort = 1'b0;
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = 19'd0; cpu_wdata = 8'h00;
    cfg_x0 = 10'd0; cfg_y0 = 9'd0; cfg_w = 10'd0; cfg_h = 9'd0; cfg_color = 8'h00;
    repeat (2) @(negedge main_clk);
    #1;
    total++;
    if ({busy, done, cpu_gnt, cpu_rvalid, fb_req, fb_we} !== 6'b0) begin
      bad++;
      $display("[TB] FAIL reset_flags: got %b want 000000", {busy, done, cpu_gnt, cpu_rvalid, fb_req, fb_we});
    end
    total++;
    if ({fb_addr, fb_wdata, cpu_rdata} !== 35'd0) begin
      bad++;
      $display("[TB] FAIL reset_data: got addr=%0d wdata=%h rdata=%h want 0", fb_addr, fb_wdata, cpu_rdata);
    end
    @(negedge main_clk);
    res = 1'b0;
    #1;
    total++;
    if ({busy, done, fb_req} !== 3'b000) begin
      bad++;
      $display("[TB] FAIL reset_release: got %b want 000", {busy, done, fb_req});
    end
  endtask

  task automatic test_plain_fill;
    logic [18:0] exp_addr [6];
    exp_addr = '{19'd12810, 19'd12811, 19'd12812, 19'd13450, 19'd13451, 19'd13452};
    @(negedge main_clk);
    cfg_x0 = 10'd10; cfg_y0 = 9'd20; cfg_w = 10'd3; cfg_h = 9'd2; cfg_color = 8'h5A;
    start = 1'b1;
    #1;
    total++;
    if (busy !== 1'b0) begin
      bad++;
      $display("[TB] FAIL plain_start_busy: got %b want 0", busy);
    end
    for (int k = 1; k <= 8; k++) begin
      @(negedge main_clk);
      start = (k == 3);
      if (k == 3) begin
        cfg_x0 = 10'd200; cfg_color = 8'hFF;
      end
      #1;
      if (k <= 6) begin
        total++;
        if ({fb_req, fb_we, busy, done} !== 4'b1110) begin
          bad++;
          $display("[TB] FAIL plain_flags[%0d]: got %b want 1110", k, {fb_req, fb_we, busy, done});
        end
        total++;
        if (fb_addr !== exp_addr[k-1] || fb_wdata !== 8'h5A) begin
          bad++;
          $display("[TB] FAIL plain_write[%0d]: got addr=%0d data=%h want addr=%0d data=5a", k, fb_addr, fb_wdata, exp_addr[k-1]);
        end
      end else begin
        total++;
        if ({fb_req, busy, done} !== ((k == 7) ? 3'b001 : 3'b000)) begin
          bad++;
          $display("[TB] FAIL plain_end[%0d]: got %b want %b", k, {fb_req, busy, done}, (k == 7) ? 3'b001 : 3'b000);
        end
      end
    end
    start = 1'b0;
  endtask

  task automatic test_clipped_fill;
    @(negedge main_clk);
    cfg_x0 = 10'd638; cfg_y0 = 9'd479; cfg_w = 10'd5; cfg_h = 9'd4; cfg_color = 8'hC3;
    start = 1'b1;
    #1;
    for (int k = 1; k <= 3; k++) begin
      @(negedge main_clk);
      start = 1'b0;
      #1;
      if (k <= 2) begin
        total++;
        if (fb_req !== 1'b1 || fb_we !== 1'b1 || fb_addr !== 19'(307197 + k) || fb_wdata !== 8'hC3) begin
          bad++;
          $display("[TB] FAIL clip_write[%0d]: got req=%b addr=%0d data=%h want req=1 addr=%0d data=c3", k, fb_req, fb_addr, fb_wdata, 307197 + k);
        end
      end else begin
        total++;
        if ({fb_req, busy, done} !== 3'b001) begin
          bad++;
          $display("[TB] FAIL clip_done: got %b want 001", {fb_req, busy, done});
        end
      end
    end
  endtask

  task automatic test_degenerate;
    for (int c = 0; c < 2; c++) begin
      @(negedge main_clk);
      cfg_x0 = (c == 0) ? 10'd5 : 10'd700;
      cfg_y0 = 9'd3;
      cfg_w  = (c == 0) ? 10'd0 : 10'd4;
      cfg_h  = 9'd2;
      start  = 1'b1;
      #1;
      total++;
      if (fb_req !== 1'b0) begin
        bad++;
        $display("[TB] FAIL degen_start_req[%0d]: got %b want 0", c, fb_req);
      end
      @(negedge main_clk);
      start = 1'b0;
      #1;
      total++;
      if ({fb_req, busy, done} !== 3'b001) begin
        bad++;
        $display("[TB] FAIL degen_done[%0d]: got %b want 001", c, {fb_req, busy, done});
      end
      @(negedge main_clk);
      #1;
      total++;
      if ({fb_req, busy, done} !== 3'b000) begin
        bad++;
        $display("[TB] FAIL degen_idle[%0d]: got %b want 000", c, {fb_req, busy, done});
      end
    end
  endtask

  task automatic test_contention;
    int  pix;
    logic eng;
    pix = 0;
    @(negedge main_clk);
    cfg_x0 = 10'd0; cfg_y0 = 9'd0; cfg_w = 10'd100; cfg_h = 9'd1; cfg_color = 8'h11;
    start = 1'b1;
    #1;
    for (int k = 1; k <= 120; k++) begin
      @(negedge main_clk);
      start     = 1'b0;
      cpu_req   = (k <= 20);
      cpu_we    = 1'b1;
      cpu_addr  = 19'(1000 + k);
      cpu_wdata = 8'(k);
      #1;
      eng = (k <= 20) ? (k == 9 || k == 18) : (k <= 118);
      if (eng) begin
        total++;
        if ({fb_req, fb_we, cpu_gnt} !== 3'b110 || fb_addr !== 19'(pix) || fb_wdata !== 8'h11) begin
          bad++;
          $display("[TB] FAIL cont_engine[%0d]: got req/we/gnt=%b addr=%0d data=%h want 110 addr=%0d data=11", k, {fb_req, fb_we, cpu_gnt}, fb_addr, fb_wdata, pix);
        end
        pix++;
      end else if (k <= 20) begin
        total++;
        if ({fb_req, cpu_gnt, busy} !== 3'b111 || fb_addr !== 19'(1000 + k) || fb_wdata !== 8'(k)) begin
          bad++;
          $display("[TB] FAIL cont_cpu[%0d]: got req/gnt/busy=%b addr=%0d data=%h want 111 addr=%0d data=%h", k, {fb_req, cpu_gnt, busy}, fb_addr, fb_wdata, 1000 + k, 8'(k));
        end
      end else begin
        total++;
        if ({fb_req, busy, done} !== ((k == 119) ? 3'b001 : 3'b000)) begin
          bad++;
          $display("[TB] FAIL cont_end[%0d]: got %b want %b", k, {fb_req, busy, done}, (k == 119) ? 3'b001 : 3'b000);
        end
      end
    end
    cpu_req = 1'b0;
    cpu_we  = 1'b0;
  endtask

  task automatic test_cpu_access;
    @(negedge main_clk);
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 19'd77; cpu_wdata = 8'h3C;
    #1;
    total++;
    if ({cpu_gnt, fb_req, fb_we} !== 3'b111 || fb_addr !== 19'd77 || fb_wdata !== 8'h3C) begin
      bad++;
      $display("[TB] FAIL cpu_write: got gnt/req/we=%b addr=%0d data=%h want 111 addr=77 data=3c", {cpu_gnt, fb_req, fb_we}, fb_addr, fb_wdata);
    end
    for (int k = 0; k <= 4; k++) begin
      @(negedge main_clk);
      cpu_req  = (k <= 1);
      cpu_we   = 1'b0;
      cpu_addr = (k == 0) ? 19'd100 : 19'd101;
      #1;
      if (k <= 1) begin
        total++;
        if ({cpu_gnt, fb_req, fb_we} !== 3'b110 || fb_addr !== cpu_addr) begin
          bad++;
          $display("[TB] FAIL cpu_read_issue[%0d]: got gnt/req/we=%b addr=%0d want 110 addr=%0d", k, {cpu_gnt, fb_req, fb_we}, fb_addr, cpu_addr);
        end
      end
      total++;
      if (cpu_rvalid !== (k == 2 || k == 3)) begin
        bad++;
        $display("[TB] FAIL cpu_rvalid[%0d]: got %b want %b", k, cpu_rvalid, (k == 2 || k == 3));
      end
      if (k == 2 || k == 3) begin
        total++;
        if (cpu_rdata !== ((k == 2) ? 8'h94 : 8'h95)) begin
          bad++;
          $display("[TB] FAIL cpu_rdata[%0d]: got %h want %h", k, cpu_rdata, (k == 2) ? 8'h94 : 8'h95);
        end
      end
    end
  endtask

  task automatic test_abort;
    @(negedge main_clk);
    cfg_x0 = 10'd1; cfg_y0 = 9'd1; cfg_w = 10'd3; cfg_h = 9'd3; cfg_color = 8'h77;
    start = 1'b1;
    #1;
    for (int k = 1; k <= 8; k++) begin
      @(negedge main_clk);
      start = 1'b0;
      abort = (k == 6);
      #1;
      if (k <= 5) begin
        total++;
        if (fb_req !== 1'b1 || fb_addr !== ((k <= 3) ? 19'(640 + k) : 19'(1277 + k))) begin
          bad++;
          $display("[TB] FAIL abort_write[%0d]: got req=%b addr=%0d want req=1 addr=%0d", k, fb_req, fb_addr, (k <= 3) ? 640 + k : 1277 + k);
        end
      end else begin
        total++;
        if ({fb_req, busy, done} !== ((k == 6) ? 3'b010 : (k == 7) ? 3'b001 : 3'b000)) begin
          bad++;
          $display("[TB] FAIL abort_seq[%0d]: got %b want %b", k, {fb_req, busy, done}, (k == 6) ? 3'b010 : (k == 7) ? 3'b001 : 3'b000);
        end
      end
    end
    abort = 1'b0;
    @(negedge main_clk);
    cfg_x0 = 10'd0; cfg_y0 = 9'd0; cfg_w = 10'd1; cfg_h = 9'd1; cfg_color = 8'hE1;
    start = 1'b1;
    #1;
    @(negedge main_clk);
    start = 1'b0;
    #1;
    total++;
    if ({fb_req, fb_we, busy} !== 3'b111 || fb_addr !== 19'd0 || fb_wdata !== 8'hE1) begin
      bad++;
      $display("[TB] FAIL restart_write: got req/we/busy=%b addr=%0d data=%h want 111 addr=0 data=e1", {fb_req, fb_we, busy}, fb_addr, fb_wdata);
    end
    @(negedge main_clk);
    #1;
    total++;
    if ({fb_req, busy, done} !== 3'b001) begin
      bad++;
      $display("[TB] FAIL restart_done: got %b want 001", {fb_req, busy, done});
    end
  endtask

  task automatic test_reset_mid_fill;
    @(negedge main_clk);
    cfg_x0 = 10'd0; cfg_y0 = 9'd5; cfg_w = 10'd10; cfg_h = 9'd1; cfg_color = 8'h42;
    start = 1'b1;
    #1;
    for (int k = 1; k <= 6; k++) begin
      @(negedge main_clk);
      start = 1'b0;
      res   = (k == 4);
      #1;
      if (k <= 3) begin
        total++;
        if (fb_req !== 1'b1 || fb_addr !== 19'(3199 + k)) begin
          bad++;
          $display("[TB] FAIL rst_pre_write[%0d]: got req=%b addr=%0d want req=1 addr=%0d", k, fb_req, fb_addr, 3199 + k);
        end
      end else if (k >= 5) begin
        total++;
        if ({busy, done, cpu_gnt, cpu_rvalid, fb_req, fb_we} !== 6'b0 || {fb_addr, fb_wdata, cpu_rdata} !== 35'd0) begin
          bad++;
          $display("[TB] FAIL rst_mid[%0d]: got flags=%b addr=%0d wdata=%h rdata=%h want all 0", k, {busy, done, cpu_gnt, cpu_rvalid, fb_req, fb_we}, fb_addr, fb_wdata, cpu_rdata);
        end
      end
    end
    res = 1'b0;
  endtask

  initial begin
    test_reset();
    test_plain_fill();
    test_clipped_fill();
    test_degenerate();
    test_contention();
    test_cpu_access();
    test_abort();
    test_reset_mid_fill();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
